// File: rtl/vga_sync_receiver_if.sv
// Sync-side bundle of the VGA receiver: pixel tick and syncs in, reconstructed
// timing, lock status and fault counters out.
interface vga_sync_receiver_if;
  logic        p_pixel;
  logic        hsync;
  logic        vsync;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        line_start;
  logic        frame_start;
  logic        locked;
  logic        sync_err;
  logic [7:0]  err_count;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;

  modport master (
    output p_pixel, hsync, vsync,
    input  x, y, video_on, line_start, frame_start, locked, sync_err,
           err_count, line_len, frame_lines
  );

  modport slave (
    input  p_pixel, hsync, vsync,
    output x, y, video_on, line_start, frame_start, locked, sync_err,
           err_count, line_len, frame_lines
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: rebuilds x/y from hsync/vsync edges, measures line and
// frame periods, and qualifies the timing through a SEARCH/VERIFY/LOCKED FSM.
module vga_sync_receiver #(
  parameter int HD           = 640,
  parameter int VD           = 480,
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_SYNC_START = 656,
  parameter int V_SYNC_START = 513,
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT      = 1600
) (
  input  logic               clk,
  input  logic               reset_n,
  vga_sync_receiver_if.slave bus
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [10:0]   LINE_OK   = 11'(H_TOTAL);
  localparam logic [9:0]    FRAME_OK  = 10'(V_TOTAL);
  localparam logic [9:0]    X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    X_SYNC    = 10'(H_SYNC_START);
  localparam logic [9:0]    Y_SYNC    = 10'(V_SYNC_START);
  localparam logic [9:0]    X_VIS     = 10'(HD);
  localparam logic [9:0]    Y_VIS     = 10'(VD);
  localparam logic [10:0]   TO_LAST   = 11'(TIMEOUT - 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);
  localparam logic [GW-1:0] GOOD_ONE  = GW'(1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t      state;
  logic        hs_prev, vs_prev;
  logic        h_valid, line_bad_seen;
  logic        locked_q, line_start_q, frame_start_q, sync_err_q;
  logic [9:0]  x_q, y_q, v_meas, frame_lines_q;
  logic [10:0] h_meas, line_len_q;
  logic [7:0]  err_q;
  logic [GW-1:0] good;

  logic        tick, hs_edge, vs_edge, x_wrap;
  logic        line_bad, frame_bad, timeout;
  logic [10:0] line_len_nxt;
  logic [9:0]  frame_lines_nxt;

  assign tick    = bus.p_pixel;
  assign hs_edge = tick && bus.hsync && !hs_prev;
  assign vs_edge = tick && bus.vsync && !vs_prev;
  assign x_wrap  = (x_q == X_LAST);

  assign line_len_nxt    = (h_meas == 11'h7FF) ? 11'h7FF : h_meas + 11'd1;
  assign frame_lines_nxt = (hs_edge && v_meas != 10'h3FF) ? v_meas + 10'd1 : v_meas;

  // h_valid guards the first edge after reset/SEARCH, whose period is unknown.
  assign line_bad  = hs_edge && h_valid && (line_len_nxt != LINE_OK);
  assign frame_bad = vs_edge && ((frame_lines_nxt != FRAME_OK) || line_bad_seen || line_bad);
  // h_meas doubles as the ticks-since-last-hsync-edge counter.
  assign timeout   = tick && !hs_edge && (h_meas == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SEARCH;
      hs_prev       <= 1'b0;
      vs_prev       <= 1'b0;
      h_valid       <= 1'b0;
      line_bad_seen <= 1'b0;
      locked_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      v_meas        <= '0;
      frame_lines_q <= '0;
      h_meas        <= '0;
      line_len_q    <= '0;
      err_q         <= '0;
      good          <= '0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (tick) begin
        hs_prev       <= bus.hsync;
        vs_prev       <= bus.vsync;
        line_start_q  <= hs_edge;
        frame_start_q <= vs_edge;

        if (hs_edge)     x_q <= X_SYNC;
        else if (x_wrap) x_q <= '0;
        else             x_q <= x_q + 10'd1;

        if (vs_edge)                 y_q <= Y_SYNC;
        else if (!hs_edge && x_wrap) y_q <= (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;

        if (hs_edge) begin
          line_len_q <= line_len_nxt;
          h_meas     <= '0;
          h_valid    <= 1'b1;
        end else if (h_meas != 11'h7FF) begin
          h_meas <= h_meas + 11'd1;
        end

        if (vs_edge) begin
          frame_lines_q <= frame_lines_nxt;
          v_meas        <= '0;
        end else begin
          v_meas <= frame_lines_nxt;
        end

        if (vs_edge)       line_bad_seen <= 1'b0;
        else if (line_bad) line_bad_seen <= 1'b1;

        if (timeout) begin
          state    <= SEARCH;
          locked_q <= 1'b0;
          good     <= '0;
          h_valid  <= 1'b0;
          if (state == LOCKED) begin
            sync_err_q <= 1'b1;
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
          end
        end else begin
          case (state)
            SEARCH: if (vs_edge) begin
              state <= VERIFY;
              good  <= '0;
            end
            VERIFY: if (vs_edge) begin
              if (frame_bad) begin
                good <= '0;
              end else if (good + GOOD_ONE == GOOD_LOCK) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                good     <= '0;
              end else begin
                good <= good + GOOD_ONE;
              end
            end
            LOCKED: if (line_bad || frame_bad) begin
              sync_err_q <= 1'b1;
              if (err_q != 8'hFF) err_q <= err_q + 8'd1;
              state    <= VERIFY;
              locked_q <= 1'b0;
              good     <= '0;
            end
            default: state <= SEARCH;
          endcase
        end
      end
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.video_on    = locked_q && (x_q < X_VIS) && (y_q < Y_VIS);
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.err_count   = err_q;
  assign bus.line_len    = line_len_q;
  assign bus.frame_lines = frame_lines_q;

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive-side counterpart of the 640x480 VGA timing generator.
- Samples hsync/vsync on the pixel tick, measures line length and frame height, and reconstructs x/y pixel coordinates from the sync edges.
- Qualifies the timing through a lock state machine, and reports timing faults and counts them.
- Used as a loopback/self-check monitor on the display path, or as the front end of a capture path fed by a sync source.

Parameters:
- HD, 640, horizontal display width in pixels
- VD, 480, vertical display height in lines
- H_TOTAL, 800, expected pixel ticks per line
- V_TOTAL, 525, expected lines per frame
- H_SYNC_START, 656, x value on the tick hsync is first sampled high
- V_SYNC_START, 513, y value on the tick vsync is first sampled high
- LOCK_FRAMES, 2, consecutive clean frames required to lock
- TIMEOUT, 1600, pixel ticks without an hsync edge before returning to SEARCH

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- p_pixel  in  1  pixel tick, one clk wide; all logic advances only when high
- hsync  in  1  horizontal sync, high during retrace
- vsync  in  1  vertical sync, high during retrace
- x  out  10  reconstructed horizontal coordinate
- y  out  10  reconstructed vertical coordinate
- video_on  out  1  locked && x<HD && y<VD
- line_start  out  1  one-clk pulse on an hsync rising edge
- frame_start  out  1  one-clk pulse on a vsync rising edge
- locked  out  1  high in LOCKED state
- sync_err  out  1  one-clk pulse on a timing fault while in LOCKED
- err_count  out  8  saturating count of sync_err pulses
- line_len  out  11  last measured hsync-to-hsync period, in ticks
- frame_lines  out  10  last measured vsync-to-vsync period, in lines

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs and internal registers go to 0; state goes to SEARCH.
  - Reset mid-frame discards all measurements.
- Sampling and edge detection:
  - hsync and vsync are sampled only on ticks (p_pixel=1). Previous-sample registers also update only on ticks.
  - An edge is detected on a tick where the sample is 1 and the previous sample was 0.
  - All pulse outputs are registered and asserted for exactly one clk: the clk following the edge-detecting tick.
- x counter:
  - hsync edge: x <= H_SYNC_START.
  - Otherwise, on a tick, x increments and wraps at H_TOTAL-1 to 0.
- y counter:
  - vsync edge: y <= V_SYNC_START. This has priority over the x-wrap increment on the same tick.
  - Otherwise, x wrapping to 0 increments y, which wraps at V_TOTAL-1 to 0.
- Line length measurement:
  - Internal tick counter h_meas, 11-bit, saturating at 2047.
  - On an hsync edge: line_len <= h_meas + 1 (saturating), then h_meas <= 0.
  - Otherwise h_meas increments every tick.
- Frame height measurement:
  - Internal line counter v_meas, 10-bit, saturating; counts hsync edges.
  - On a vsync edge: frame_lines <= v_meas, plus 1 if an hsync edge occurs on the same tick. Then v_meas <= 0.
- Line and frame checks:
  - line_bad: an hsync edge where the new line_len != H_TOTAL. Edges while h_meas is uninitialised after reset/SEARCH are not checked.
  - frame_bad: a vsync edge where frame_lines != V_TOTAL, or any line_bad occurred since the previous vsync edge.
- Lock FSM:
  - SEARCH: wait for the first vsync edge -> VERIFY with good=0. The first frame is never judged.
  - VERIFY, on each subsequent vsync edge:
    - frame_bad -> good <= 0, stay in VERIFY.
    - Clean frame -> good++.
    - good reaches LOCK_FRAMES -> LOCKED.
  - LOCKED:
    - Any line_bad or frame_bad -> sync_err pulse, err_count++ (saturating at 255), go to VERIFY with good=0.
    - line_bad and frame_bad on the same tick produce a single pulse.
- Timeout:
  - In any state, TIMEOUT consecutive ticks with no hsync edge -> SEARCH.
  - On timeout from LOCKED, sync_err pulses once.
  - x, y and err_count are retained.
- locked and video_on:
  - locked is high only in LOCKED.
  - video_on is forced 0 whenever not locked.
- Ticks absent: with p_pixel held low, all state is frozen.

Test Plan:
- Drive a nominal 800x525 timing (hsync high x=656..751, vsync high y=513..514) from reset -> locked rises at the 3rd vsync edge; line_len=800, frame_lines=525; video_on high exactly at x<640, y<480.
- Locked stream; one line stretched to 801 ticks -> single sync_err pulse, err_count=1, locked drops, relocks after 2 further clean frames.
- Frame of 524 lines while locked -> frame_lines=524, sync_err pulse, err_count=1.
- Stop hsync for 1600 ticks -> state SEARCH, locked=0, video_on=0; resume -> relock after SEARCH + 2 clean frames.
- Assert reset_n low mid-frame at x=300, y=200 -> all outputs 0 immediately (asynchronous); after release, behaves as from power-up.
- Inject 300 faults -> err_count saturates at 255; p_pixel held low for 50 clks -> x/y unchanged.
